fir_cmplx_dec: RTL



---
 rtl/fir_cmplx_dec.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fir_cmplx_dec.sv
// Complex-coefficient decimating FIR: pops DECIMATION I/Q samples, then runs one
// complex tap per cycle and pushes one narrowed complex output.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_READ  | pop I/Q pairs into the history until DECIMATION have arrived
// ST_MAC   | accumulate tap cnt of the complex product, one tap per cycle
// ST_WRITE | hold the narrowed result until both sink FIFOs accept it
module fir_cmplx_dec #(
   parameter int DATA_WIDTH = 32,
   parameter int COEF_WIDTH = 32,
   parameter int ACC_WIDTH  = 48,
   parameter int TAPS       = 20,
   parameter int DECIMATION = 1,
   parameter int QUANT_BITS = 10,
   parameter bit SATURATE   = 1'b1,
   parameter logic [0:TAPS-1][COEF_WIDTH-1:0] H_REAL = '0,
   parameter logic [0:TAPS-1][COEF_WIDTH-1:0] H_IMAG = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_in,
   input  logic [DATA_WIDTH-1:0] q_in,
   input  logic                  i_empty,
   input  logic                  q_empty,
   output logic                  i_rd_en,
   output logic                  q_rd_en,
   output logic [DATA_WIDTH-1:0] y_real_out,
   output logic [DATA_WIDTH-1:0] y_imag_out,
   output logic                  y_real_wr_en,
   output logic                  y_imag_wr_en,
   input  logic                  y_real_full,
   input  logic                  y_imag_full,
   output logic                  overflow
);

   localparam int CW = $clog2(TAPS);
   localparam int PW = DATA_WIDTH + COEF_WIDTH;

   typedef enum logic [1:0] {
      ST_READ  = 2'd0,
      ST_MAC   = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0] cnt;
   logic signed [DATA_WIDTH-1:0] xr [0:TAPS-1];
   logic signed [DATA_WIDTH-1:0] xi [0:TAPS-1];
   logic signed [ACC_WIDTH-1:0] acc_r, acc_i, acc_r_nxt, acc_i_nxt;
   logic signed [COEF_WIDTH-1:0] hr, hi;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [ACC_WIDTH-1:0] s_rr, s_ii, s_ri, s_ir;
   logic [DATA_WIDTH-1:0] yr_nar, yi_nar;
   logic ovf_r, ovf_i;
   logic rd, wr;
   logic last_read, last_tap;

   // Returns {overflow, narrowed value}; overflow whenever the bits above the
   // output sign bit are not a pure sign extension.
   function automatic logic [DATA_WIDTH:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
      logic [ACC_WIDTH-DATA_WIDTH:0] top;
      logic                          ov;
      logic [DATA_WIDTH-1:0]         v;
      top = a[ACC_WIDTH-1:DATA_WIDTH-1];
      ov  = !((&top) || !(|top));
      v   = a[DATA_WIDTH-1:0];
      if (ov && SATURATE)
         v = a[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      return {ov, v};
   endfunction

   assign last_read = (cnt == CW'(DECIMATION - 1));
   assign last_tap  = (cnt == CW'(TAPS - 1));

   always_comb begin
      hr   = H_REAL[cnt];
      hi   = H_IMAG[cnt];
      p_rr = PW'(hr) * PW'(xr[cnt]);
      p_ii = PW'(hi) * PW'(xi[cnt]);
      p_ri = PW'(hr) * PW'(xi[cnt]);
      p_ir = PW'(hi) * PW'(xr[cnt]);
      s_rr = ACC_WIDTH'(p_rr >>> QUANT_BITS);
      s_ii = ACC_WIDTH'(p_ii >>> QUANT_BITS);
      s_ri = ACC_WIDTH'(p_ri >>> QUANT_BITS);
      s_ir = ACC_WIDTH'(p_ir >>> QUANT_BITS);
      acc_r_nxt = acc_r + s_rr - s_ii;
      acc_i_nxt = acc_i + s_ri + s_ir;
      {ovf_r, yr_nar} = narrow(acc_r_nxt);
      {ovf_i, yi_nar} = narrow(acc_i_nxt);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_READ;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_READ:  if (rd && last_read) state_nxt = ST_MAC;
         ST_MAC:   if (last_tap)        state_nxt = ST_WRITE;
         ST_WRITE: if (wr)              state_nxt = ST_READ;
         default:                       state_nxt = ST_READ;
      endcase
   end

   always_comb begin
      rd = 1'b0;
      wr = 1'b0;
      case (state)
         ST_READ:  rd = !i_empty && !q_empty;
         ST_WRITE: wr = !y_real_full && !y_imag_full;
         default: ;
      endcase
      i_rd_en      = rd;
      q_rd_en      = rd;
      y_real_wr_en = wr;
      y_imag_wr_en = wr;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         acc_r      <= '0;
         acc_i      <= '0;
         y_real_out <= '0;
         y_imag_out <= '0;
         overflow   <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            xr[k] <= '0;
            xi[k] <= '0;
         end
      end else begin
         case (state)
            ST_READ: begin
               if (rd) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     xr[k] <= xr[k-1];
                     xi[k] <= xi[k-1];
                  end
                  xr[0] <= i_in;
                  xi[0] <= q_in;
                  if (last_read) begin
                     cnt   <= '0;
                     acc_r <= '0;
                     acc_i <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_MAC: begin
               acc_r <= acc_r_nxt;
               acc_i <= acc_i_nxt;
               if (last_tap) begin
                  cnt        <= '0;
                  y_real_out <= yr_nar;
                  y_imag_out <= yi_nar;
                  overflow   <= overflow | ovf_r | ovf_i;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WRITE: if (wr) cnt <= '0;
            default:  cnt <= '0;
         endcase
      end
   end

endmodule
